// File: rtl/dmem_if.sv
// Load/store port between the core's LSU (master) and the data-memory responder (slave).
// Byte-lane enables select which lanes of the 32-bit word take part in a request.
interface dmem_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_responder.sv
// Byte-enabled word memory that answers each load/store request with a single
// response pulse a fixed LATENCY cycles after the request was sampled.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready; a request is captured (LATENCY=1 completes here)
// ST_WAIT | transaction outstanding; count down, complete at count 0
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus,
  output logic   busy,
  output logic   err_drop
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   hold_idx;
  logic [3:0]      hold_rmask, hold_wmask;
  logic [31:0]     hold_wdata;
  logic            req, capture, complete, drop;
  logic [IW-1:0]   req_idx, c_idx;
  logic [3:0]      c_rmask, c_wmask;
  logic [31:0]     c_wdata, c_word, rdata_c;
  logic [31:0]     mem [DEPTH];
  logic            unused_addr;

  assign req         = |(bus.dmem_rmask | bus.dmem_wmask);
  assign req_idx     = bus.dmem_addr[IW+1:2];
  assign unused_addr = ^{bus.dmem_addr[31:IW+2], bus.dmem_addr[1:0]};
  assign busy        = (state == ST_WAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    complete  = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (LATENCY == 1) begin
            complete = 1'b1;
          end else begin
            cnt_nxt   = CW'(LATENCY - 2);
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        drop = req;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the completion uses the live request rather than the holding regs.
  always_comb begin
    c_idx   = (LATENCY == 1) ? req_idx         : hold_idx;
    c_rmask = (LATENCY == 1) ? bus.dmem_rmask  : hold_rmask;
    c_wmask = (LATENCY == 1) ? bus.dmem_wmask  : hold_wmask;
    c_wdata = (LATENCY == 1) ? bus.dmem_wdata  : hold_wdata;
    c_word  = mem[c_idx];
    rdata_c = '0;
    for (int i = 0; i < 4; i++) begin
      if (c_rmask[i]) begin
        rdata_c[8*i +: 8] = c_wmask[i] ? c_wdata[8*i +: 8] : c_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      hold_idx       <= '0;
      hold_rmask     <= '0;
      hold_wmask     <= '0;
      hold_wdata     <= '0;
      bus.dmem_resp  <= 1'b0;
      bus.dmem_rdata <= '0;
      err_drop       <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        hold_idx   <= req_idx;
        hold_rmask <= bus.dmem_rmask;
        hold_wmask <= bus.dmem_wmask;
        hold_wdata <= bus.dmem_wdata;
      end
      bus.dmem_resp  <= complete;
      bus.dmem_rdata <= complete ? rdata_c : 32'h0;
      err_drop       <= err_drop | drop;
    end
  end

  // Array is deliberately not reset; a write only lands on a completion edge.
  always_ff @(posedge clk) begin
    if (rst_n && complete) begin
      for (int i = 0; i < 4; i++) begin
        if (c_wmask[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 1, 2, 3) share one
// request stream, and sel picks which instance sees the request and is observed.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic [3:0]  rmask, wmask;
  int          sel;
  int          checks = 0;
  int          failures = 0;

  logic        busy1, busy2, busy3, err1, err2, err3;
  logic        resp_s, busy_s, err_s;
  logic [31:0] rdata_s;

  dmem_if b1 ();
  dmem_if b2 ();
  dmem_if b3 ();

  assign b1.dmem_addr  = addr;
  assign b1.dmem_wdata = wdata;
  assign b1.dmem_rmask = (sel == 1) ? rmask : 4'h0;
  assign b1.dmem_wmask = (sel == 1) ? wmask : 4'h0;
  assign b2.dmem_addr  = addr;
  assign b2.dmem_wdata = wdata;
  assign b2.dmem_rmask = (sel == 2) ? rmask : 4'h0;
  assign b2.dmem_wmask = (sel == 2) ? wmask : 4'h0;
  assign b3.dmem_addr  = addr;
  assign b3.dmem_wdata = wdata;
  assign b3.dmem_rmask = (sel == 3) ? rmask : 4'h0;
  assign b3.dmem_wmask = (sel == 3) ? wmask : 4'h0;

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1), .err_drop(err1));
  dmem_responder #(.DEPTH(256), .LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2), .err_drop(err2));
  dmem_responder #(.DEPTH(256), .LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3), .err_drop(err3));

  always #5 clk = ~clk;

  always_comb begin
    resp_s  = b2.dmem_resp;
    rdata_s = b2.dmem_rdata;
    busy_s  = busy2;
    err_s   = err2;
    case (sel)
      1: begin resp_s = b1.dmem_resp; rdata_s = b1.dmem_rdata; busy_s = busy1; err_s = err1; end
      3: begin resp_s = b3.dmem_resp; rdata_s = b3.dmem_rdata; busy_s = busy3; err_s = err3; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd);
    addr = a; rmask = rm; wmask = wm; wdata = wd;
    step();
    rmask = 4'h0; wmask = 4'h0;
  endtask

  // Called right after do_req: we are then in cycle k+1 of a request sampled in cycle k.
  task automatic wait_resp(input string name, input logic [31:0] exp);
    int n = 1;
    while (resp_s !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (resp_s !== 1'b1 || n != sel) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles (resp=%b), want %0d", name, n, resp_s, sel);
    end
    checks++;
    if (rdata_s !== exp) begin
      failures++;
      $display("FAIL %s rdata: got %h, want %h", name, rdata_s, exp);
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    sel = 2; rst_n = 1'b0; addr = '0; wdata = '0; rmask = '0; wmask = '0;
    step(); step();
    checks++;
    if ({resp_s, busy_s, err_s, rdata_s} !== 35'h0) begin
      failures++;
      $display("FAIL reset_values: got resp=%b busy=%b err=%b rdata=%h, want all 0",
               resp_s, busy_s, err_s, rdata_s);
    end
    rst_n = 1'b1;
    step();
    do_req(32'h20, 4'h0, 4'hF, 32'h0000_0000);
    wait_resp("reset_init_write", 32'h0);
    step();
    do_req(32'h20, 4'h0, 4'hF, 32'h1234_5678);
    checks++;
    if (busy_s !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy: got %b, want 1", busy_s);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_s !== 1'b0 || resp_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got busy=%b resp=%b, want 0 0", busy_s, resp_s);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_s === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_resp: got %0d responses, want 0", seen);
    end
    do_req(32'h20, 4'hF, 4'h0, 32'h0);
    wait_resp("reset_write_discarded", 32'h0);
    step();
  endtask

  task automatic test_word();
    sel = 2;
    do_req(32'h10, 4'h0, 4'hF, 32'hDEAD_BEEF);
    wait_resp("word_write", 32'h0);
    do_req(32'h10, 4'hF, 4'h0, 32'h0);
    wait_resp("word_read", 32'hDEAD_BEEF);
    step();
    checks++;
    if (resp_s !== 1'b0 || rdata_s !== 32'h0) begin
      failures++;
      $display("FAIL word_pulse_clear: got resp=%b rdata=%h, want 0 0", resp_s, rdata_s);
    end
  endtask

  task automatic test_lanes();
    sel = 2;
    do_req(32'h40, 4'h0, 4'hF, 32'h1122_3344);
    wait_resp("lanes_word", 32'h0);
    do_req(32'h40, 4'h0, 4'b0100, 32'h00AA_0000);
    wait_resp("lanes_sb", 32'h0);
    do_req(32'h40, 4'hF, 4'h0, 32'h0);
    wait_resp("lanes_read_all", 32'h11AA_3344);
    do_req(32'h40, 4'b0011, 4'h0, 32'h0);
    wait_resp("lanes_read_low", 32'h0000_3344);
    step();
  endtask

  task automatic test_dropped();
    int seen = 0;
    sel = 3;
    checks++;
    if (err_s !== 1'b0) begin
      failures++;
      $display("FAIL drop_initial_err: got %b, want 0", err_s);
    end
    do_req(32'h80, 4'h0, 4'hF, 32'h0000_0055);
    do_req(32'h84, 4'hF, 4'h0, 32'h0);
    checks++;
    if (err_s !== 1'b1 || resp_s !== 1'b0 || busy_s !== 1'b1) begin
      failures++;
      $display("FAIL drop_cycle2: got err=%b resp=%b busy=%b, want 1 0 1", err_s, resp_s, busy_s);
    end
    step();
    checks++;
    if (resp_s !== 1'b1 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL drop_resp_cycle3: got resp=%b busy=%b, want 1 0", resp_s, busy_s);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (resp_s === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || err_s !== 1'b1) begin
      failures++;
      $display("FAIL drop_after: got extra_resp=%0d err=%b, want 0 1", seen, err_s);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    logic [3:0]  rm [4];
    logic [3:0]  wm [4];
    logic [31:0] wd [4];
    logic [31:0] ex [4];
    a  = '{32'h100, 32'h100, 32'h104, 32'h104};
    rm = '{4'hF, 4'b1100, 4'h0, 4'b0011};
    wm = '{4'hF, 4'h0, 4'b0011, 4'h0};
    wd = '{32'hA5A5_A5A5, 32'h0, 32'h0000_1234, 32'h0};
    ex = '{32'hA5A5_A5A5, 32'hA5A5_0000, 32'h0, 32'h0000_1234};
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      addr = a[i]; rmask = rm[i]; wmask = wm[i]; wdata = wd[i];
      step();
      checks++;
      if (resp_s !== 1'b1 || rdata_s !== ex[i] || busy_s !== 1'b0) begin
        failures++;
        $display("FAIL b2b_req%0d: got resp=%b rdata=%h busy=%b, want 1 %h 0",
                 i, resp_s, rdata_s, busy_s, ex[i]);
      end
    end
    rmask = 4'h0; wmask = 4'h0;
    step();
    checks++;
    if (resp_s !== 1'b0 || rdata_s !== 32'h0 || busy_s !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got resp=%b rdata=%h busy=%b, want 0 0 0", resp_s, rdata_s, busy_s);
    end
  endtask

  task automatic test_alias();
    sel = 2;
    do_req(32'h0000_0400, 4'h0, 4'hF, 32'hCAFE_F00D);
    wait_resp("alias_write", 32'h0);
    do_req(32'h0000_0000, 4'hF, 4'h0, 32'h0);
    wait_resp("alias_read", 32'hCAFE_F00D);
    do_req(32'h0000_0002, 4'hF, 4'b0001, 32'h0000_00FF);
    wait_resp("alias_combined", 32'hCAFE_F0FF);
    do_req(32'h0000_0400, 4'hF, 4'h0, 32'h0);
    wait_resp("alias_readback", 32'hCAFE_F0FF);
    step();
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_dropped();
    test_back_to_back();
    test_alias();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
